// File: rtl/inst_loader_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : inst_loader_encoder
//  Purpose  : Program loader for the pipeline.  Takes symbolic instruction
//             descriptors on a valid/ready stream, encodes each into a 32-bit
//             MIPS word (the opcode/funct set the controller decodes) and
//             writes the words sequentially into instruction memory while the
//             CPU is held in reset.
//  Ports    :
//     clk, rst            clock, synchronous active-high reset
//     start, finish       open / close a load session
//     in_valid, in_ready  descriptor handshake
//     in_kind             instruction kind (0..15 legal, 16..31 illegal)
//     in_rs, in_rt, in_rd, in_shamt, in_imm, in_target   descriptor fields
//     imem_wen, imem_addr, imem_data   instruction memory write port
//     cpu_hold            CPU reset request (low only once loading is done)
//     busy                session in progress (LOAD or FLUSH)
//     count               words written in the current session
//     err_kind, err_full  sticky session error flags
//  Revision : 1.0 - initial release
// ============================================================================
module inst_loader_encoder #(
   parameter int ADDR_W = 8,
   parameter int DEPTH  = 256,
   parameter int BASE   = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              finish,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4:0]        in_kind,
   input  logic [4:0]        in_rs,
   input  logic [4:0]        in_rt,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_shamt,
   input  logic [15:0]       in_imm,
   input  logic [25:0]       in_target,
   output logic              imem_wen,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_data,
   output logic              cpu_hold,
   output logic              busy,
   output logic [ADDR_W:0]   count,
   output logic              err_kind,
   output logic              err_full
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_load  = 2'd1;
   localparam logic [1:0] c_st_flush = 2'd2;
   localparam logic [1:0] c_st_done  = 2'd3;

   localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] c_base  = ADDR_W'(BASE);

   // Descriptor kinds
   localparam logic [4:0] c_k_add  = 5'd0;
   localparam logic [4:0] c_k_sub  = 5'd1;
   localparam logic [4:0] c_k_and  = 5'd2;
   localparam logic [4:0] c_k_or   = 5'd3;
   localparam logic [4:0] c_k_slt  = 5'd4;
   localparam logic [4:0] c_k_sll  = 5'd5;
   localparam logic [4:0] c_k_srl  = 5'd6;
   localparam logic [4:0] c_k_jr   = 5'd7;
   localparam logic [4:0] c_k_j    = 5'd8;
   localparam logic [4:0] c_k_beq  = 5'd9;
   localparam logic [4:0] c_k_bne  = 5'd10;
   localparam logic [4:0] c_k_addi = 5'd11;
   localparam logic [4:0] c_k_andi = 5'd12;
   localparam logic [4:0] c_k_ori  = 5'd13;
   localparam logic [4:0] c_k_lw   = 5'd14;
   localparam logic [4:0] c_k_sw   = 5'd15;

   // Opcodes / function codes
   localparam logic [5:0] c_op_rtype = 6'h00;
   localparam logic [5:0] c_op_j     = 6'h02;
   localparam logic [5:0] c_op_beq   = 6'h04;
   localparam logic [5:0] c_op_bne   = 6'h05;
   localparam logic [5:0] c_op_addi  = 6'h08;
   localparam logic [5:0] c_op_andi  = 6'h0C;
   localparam logic [5:0] c_op_ori   = 6'h0D;
   localparam logic [5:0] c_op_lw    = 6'h23;
   localparam logic [5:0] c_op_sw    = 6'h2B;

   localparam logic [5:0] c_fn_add   = 6'h20;
   localparam logic [5:0] c_fn_sub   = 6'h22;
   localparam logic [5:0] c_fn_and   = 6'h24;
   localparam logic [5:0] c_fn_or    = 6'h25;
   localparam logic [5:0] c_fn_slt   = 6'h2A;
   localparam logic [5:0] c_fn_sll   = 6'h00;
   localparam logic [5:0] c_fn_srl   = 6'h02;
   localparam logic [5:0] c_fn_jr    = 6'h08;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [1:0]        r_state;
   logic [ADDR_W:0]   r_count;
   logic              r_wen;
   logic [ADDR_W-1:0] r_addr;
   logic [31:0]       r_data;
   logic              r_err_kind;
   logic              r_err_full;

   // ------------------------------------------------------------------------
   // Combinational
   // ------------------------------------------------------------------------
   logic        w_in_load;
   logic        w_ready;
   logic        w_accept;
   logic        w_full_hit;
   logic        w_legal;
   logic [31:0] w_word;

   assign w_in_load  = (r_state == c_st_load);
   assign w_ready    = w_in_load && (r_count < c_depth);
   assign w_accept   = in_valid && w_ready;
   assign w_full_hit = in_valid && w_in_load && (r_count == c_depth);

   // Instruction encoder. Fields a kind does not use are forced to zero so
   // the written word depends only on the fields that kind defines.
   always_comb begin
      w_legal = 1'b1;
      w_word  = 32'd0;
      case (in_kind)
         c_k_add:  w_word = {c_op_rtype, in_rs, in_rt, in_rd, 5'd0, c_fn_add};
         c_k_sub:  w_word = {c_op_rtype, in_rs, in_rt, in_rd, 5'd0, c_fn_sub};
         c_k_and:  w_word = {c_op_rtype, in_rs, in_rt, in_rd, 5'd0, c_fn_and};
         c_k_or:   w_word = {c_op_rtype, in_rs, in_rt, in_rd, 5'd0, c_fn_or};
         c_k_slt:  w_word = {c_op_rtype, in_rs, in_rt, in_rd, 5'd0, c_fn_slt};
         c_k_sll:  w_word = {c_op_rtype, 5'd0, in_rt, in_rd, in_shamt, c_fn_sll};
         c_k_srl:  w_word = {c_op_rtype, 5'd0, in_rt, in_rd, in_shamt, c_fn_srl};
         c_k_jr:   w_word = {c_op_rtype, in_rs, 5'd0, 5'd0, 5'd0, c_fn_jr};
         c_k_j:    w_word = {c_op_j, in_target};
         c_k_beq:  w_word = {c_op_beq, in_rs, in_rt, in_imm};
         c_k_bne:  w_word = {c_op_bne, in_rs, in_rt, in_imm};
         c_k_addi: w_word = {c_op_addi, in_rs, in_rt, in_imm};
         c_k_andi: w_word = {c_op_andi, in_rs, in_rt, in_imm};
         c_k_ori:  w_word = {c_op_ori, in_rs, in_rt, in_imm};
         c_k_lw:   w_word = {c_op_lw, in_rs, in_rt, in_imm};
         c_k_sw:   w_word = {c_op_sw, in_rs, in_rt, in_imm};
         default: begin
            w_legal = 1'b0;
            w_word  = 32'd0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Sequential
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= c_st_idle;
         r_count    <= '0;
         r_wen      <= 1'b0;
         r_addr     <= c_base;
         r_data     <= 32'd0;
         r_err_kind <= 1'b0;
         r_err_full <= 1'b0;
      end else begin
         // Write strobe is a single-cycle pulse following each legal accept.
         r_wen <= 1'b0;

         if (w_accept) begin
            if (w_legal) begin
               r_wen   <= 1'b1;
               // Address is taken from the pre-increment count and wraps
               // naturally at the memory's address width.
               r_addr  <= c_base + r_count[ADDR_W-1:0];
               r_data  <= w_word;
               r_count <= r_count + 1'b1;
            end else begin
               r_err_kind <= 1'b1;
            end
         end

         if (w_full_hit) begin
            r_err_full <= 1'b1;
         end

         // Session control. Accepts only happen in LOAD, so the session
         // clears on entry never collide with the accept updates above.
         case (r_state)
            c_st_idle, c_st_done: begin
               if (start) begin
                  r_state    <= c_st_load;
                  r_count    <= '0;
                  r_addr     <= c_base;
                  r_err_kind <= 1'b0;
                  r_err_full <= 1'b0;
               end
            end
            c_st_load: begin
               if (finish) begin
                  r_state <= c_st_flush;
               end
            end
            c_st_flush: begin
               // One cycle lets a beat accepted alongside finish land in
               // memory before the CPU is released.
               r_state <= c_st_done;
            end
            default: begin
               r_state <= c_st_idle;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   // Gating with rst drops a write that is pending when reset arrives.
   assign imem_wen  = r_wen && !rst;
   assign imem_addr = r_addr;
   assign imem_data = r_data;
   assign in_ready  = w_ready;
   assign cpu_hold  = (r_state != c_st_done);
   assign busy      = (r_state == c_st_load) || (r_state == c_st_flush);
   assign count     = r_count;
   assign err_kind  = r_err_kind;
   assign err_full  = r_err_full;

endmodule
`default_nettype wire

// File: tb/tb_inst_loader_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_inst_loader_encoder
//  Purpose  : Self-checking bench for inst_loader_encoder. Two instances share
//             the stimulus: a default one (ADDR_W=8, DEPTH=256, BASE=0) and a
//             small one (ADDR_W=2, DEPTH=4, BASE=2) that exercises the full
//             condition and address wrap. A session-level reference model
//             predicts every output each cycle; directed steps add known
//             constant words and addresses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_inst_loader_encoder;

   logic        clk = 1'b0;
   logic        rst, start, finish, in_valid;
   logic [4:0]  in_kind, in_rs, in_rt, in_rd, in_shamt;
   logic [15:0] in_imm;
   logic [25:0] in_target;

   logic        rdy0, wen0, hold0, busy0, ek0, ef0;
   logic [7:0]  addr0;
   logic [31:0] data0;
   logic [8:0]  count0;

   logic        rdy4, wen4, hold4, busy4, ek4, ef4;
   logic [1:0]  addr4;
   logic [31:0] data4;
   logic [2:0]  count4;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   inst_loader_encoder dut (
      .clk(clk), .rst(rst), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(rdy0), .in_kind(in_kind),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
      .in_imm(in_imm), .in_target(in_target),
      .imem_wen(wen0), .imem_addr(addr0), .imem_data(data0),
      .cpu_hold(hold0), .busy(busy0), .count(count0),
      .err_kind(ek0), .err_full(ef0)
   );

   inst_loader_encoder #(.ADDR_W(2), .DEPTH(4), .BASE(2)) dut4 (
      .clk(clk), .rst(rst), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(rdy4), .in_kind(in_kind),
      .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
      .in_imm(in_imm), .in_target(in_target),
      .imem_wen(wen4), .imem_addr(addr4), .imem_data(data4),
      .cpu_hold(hold4), .busy(busy4), .count(count4),
      .err_kind(ek4), .err_full(ef4)
   );

   // ---------------- reference model (per instance) ----------------
   // Session phase: 0 idle, 1 loading, 2 flushing, 3 done.
   int          ph[2], cnt[2], ek[2], ef[2], pend[2];
   int          paddr[2];
   logic [31:0] pdata[2];
   int          dep[2]   = '{256, 4};
   int          asize[2] = '{256, 4};
   int          base[2]  = '{0, 2};

   function automatic logic [31:0] rword(int rs, int rt, int rd, int sh, int fn);
      return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
   endfunction

   function automatic logic [31:0] iword(int op, int rs, int rt, int imm);
      return (32'(op) << 26) | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
   endfunction

   function automatic logic [31:0] enc(int k, int rs, int rt, int rd, int sh, int imm, int tgt);
      case (k)
         0:  return rword(rs, rt, rd, 0, 'h20);
         1:  return rword(rs, rt, rd, 0, 'h22);
         2:  return rword(rs, rt, rd, 0, 'h24);
         3:  return rword(rs, rt, rd, 0, 'h25);
         4:  return rword(rs, rt, rd, 0, 'h2A);
         5:  return rword(0, rt, rd, sh, 'h00);
         6:  return rword(0, rt, rd, sh, 'h02);
         7:  return rword(rs, 0, 0, 0, 'h08);
         8:  return (32'h2 << 26) | 32'(tgt);
         9:  return iword('h04, rs, rt, imm);
         10: return iword('h05, rs, rt, imm);
         11: return iword('h08, rs, rt, imm);
         12: return iword('h0C, rs, rt, imm);
         13: return iword('h0D, rs, rt, imm);
         14: return iword('h23, rs, rt, imm);
         15: return iword('h2B, rs, rt, imm);
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_update(int d);
      bit rdy;
      if (rst) begin
         ph[d] = 0; cnt[d] = 0; ek[d] = 0; ef[d] = 0; pend[d] = 0;
         return;
      end
      pend[d] = 0;
      rdy = (ph[d] == 1) && (cnt[d] < dep[d]);
      if (in_valid && ph[d] == 1 && cnt[d] == dep[d]) ef[d] = 1;
      if (in_valid && rdy) begin
         if (in_kind < 16) begin
            pend[d]  = 1;
            paddr[d] = (base[d] + cnt[d]) % asize[d];
            pdata[d] = enc(in_kind, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target);
            cnt[d]++;
         end else begin
            ek[d] = 1;
         end
      end
      case (ph[d])
         0, 3: if (start) begin ph[d] = 1; cnt[d] = 0; ek[d] = 0; ef[d] = 0; end
         1:    if (finish) ph[d] = 2;
         default: ph[d] = 3;
      endcase
   endtask

   // ---------------- checking ----------------
   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic compare(int d, logic rdy, logic wen, logic [31:0] addr,
                          logic [31:0] data, logic hold, logic bsy,
                          logic [31:0] c, logic k, logic f);
      int exp_wen;
      exp_wen = (pend[d] != 0 && !rst) ? 1 : 0;
      chk($sformatf("d%0d_in_ready", d), 32'(rdy), 32'((ph[d] == 1 && cnt[d] < dep[d]) ? 1 : 0));
      chk($sformatf("d%0d_imem_wen", d), 32'(wen), 32'(exp_wen));
      if (exp_wen != 0) begin
         chk($sformatf("d%0d_imem_addr", d), addr, 32'(paddr[d]));
         chk($sformatf("d%0d_imem_data", d), data, pdata[d]);
      end
      chk($sformatf("d%0d_cpu_hold", d), 32'(hold), 32'((ph[d] != 3) ? 1 : 0));
      chk($sformatf("d%0d_busy", d), 32'(bsy), 32'((ph[d] == 1 || ph[d] == 2) ? 1 : 0));
      chk($sformatf("d%0d_count", d), c, 32'(cnt[d]));
      chk($sformatf("d%0d_err_kind", d), 32'(k), 32'(ek[d]));
      chk($sformatf("d%0d_err_full", d), 32'(f), 32'(ef[d]));
   endtask

   // Applies the current inputs across one rising edge, then checks at the
   // following falling edge.
   task automatic tick();
      model_update(0);
      model_update(1);
      @(posedge clk);
      @(negedge clk);
      compare(0, rdy0, wen0, 32'(addr0), data0, hold0, busy0, 32'(count0), ek0, ef0);
      compare(1, rdy4, wen4, 32'(addr4), data4, hold4, busy4, 32'(count4), ek4, ef4);
   endtask

   task automatic idle_inputs();
      start = 0; finish = 0; in_valid = 0;
   endtask

   task automatic beat(int k, int rs, int rt, int rd, int sh, int imm, int tgt);
      in_valid = 1; in_kind = 5'(k); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
      in_shamt = 5'(sh); in_imm = 16'(imm); in_target = 26'(tgt);
   endtask

   // Back-to-back directed program: kind, rs, rt, rd, shamt, imm, target, word
   int          bk[6]   = '{11, 14, 9, 8, 5, 7};
   int          brs[6]  = '{0, 1, 1, 0, 7, 31};
   int          brt[6]  = '{1, 2, 2, 0, 2, 5};
   int          brd[6]  = '{0, 0, 0, 0, 4, 0};
   int          bsh[6]  = '{0, 0, 0, 0, 3, 0};
   int          bimm[6] = '{5, 4, 'hFFFF, 0, 0, 0};
   int          btgt[6] = '{0, 0, 0, 'h10, 0, 0};
   logic [31:0] bword[6] = '{32'h20010005, 32'h8C220004, 32'h1022FFFF,
                             32'h08000010, 32'h000220C0, 32'h03E00008};

   initial begin
      rst = 1; idle_inputs(); beat(0, 0, 0, 0, 0, 0, 0); in_valid = 0;

      // Reset state
      tick(); tick();
      chk("rst_imem_addr0", 32'(addr0), 32'd0);
      chk("rst_imem_addr4", 32'(addr4), 32'd2);
      chk("rst_imem_data0", data0, 32'd0);
      chk("rst_cpu_hold0", 32'(hold0), 32'd1);

      // First write: ADD rd=3 rs=1 rt=2
      rst = 0; start = 1; tick(); start = 0;
      beat(0, 1, 2, 3, 9, 0, 0); tick(); in_valid = 0;
      chk("add_wen", 32'(wen0), 32'd1);
      chk("add_addr", 32'(addr0), 32'd0);
      chk("add_data", data0, 32'h00221820);
      chk("add_count", 32'(count0), 32'd1);
      chk("add_hold", 32'(hold0), 32'd1);
      tick();
      finish = 1; tick(); finish = 0; tick();

      // New session, back-to-back beats
      start = 1; tick(); start = 0;
      for (int i = 0; i < 6; i++) begin
         beat(bk[i], brs[i], brt[i], brd[i], bsh[i], bimm[i], btgt[i]);
         tick();
         chk($sformatf("b2b%0d_wen", i), 32'(wen0), 32'd1);
         chk($sformatf("b2b%0d_addr", i), 32'(addr0), 32'(i));
         chk($sformatf("b2b%0d_data", i), data0, bword[i]);
      end

      // Illegal kind is consumed without a write
      beat(17, 1, 1, 1, 1, 1, 1); tick();
      chk("illegal_wen", 32'(wen0), 32'd0);
      chk("illegal_err_kind", 32'(ek0), 32'd1);
      chk("illegal_count", 32'(count0), 32'd6);
      beat(0, 1, 2, 3, 0, 0, 0); tick();
      chk("after_illegal_addr", 32'(addr0), 32'd6);

      // Finish alongside the last accept: write lands during FLUSH
      beat(13, 4, 5, 0, 0, 'h1234, 0); finish = 1; tick(); idle_inputs();
      chk("flush_wen", 32'(wen0), 32'd1);
      chk("flush_data", data0, 32'h34851234);
      chk("flush_hold", 32'(hold0), 32'd1);
      chk("flush_busy", 32'(busy0), 32'd1);
      tick();
      chk("done_hold", 32'(hold0), 32'd0);
      chk("done_busy", 32'(busy0), 32'd0);

      // Restart from DONE
      start = 1; tick(); start = 0;
      chk("restart_hold", 32'(hold0), 32'd1);
      chk("restart_count", 32'(count0), 32'd0);
      chk("restart_err_kind", 32'(ek0), 32'd0);
      beat(3, 1, 2, 3, 0, 0, 0); tick();
      chk("restart_addr0", 32'(addr0), 32'd0);
      chk("restart_addr4", 32'(addr4), 32'd2);

      // Fill the DEPTH=4 instance (addresses wrap 2,3,0,1), then overflow
      for (int i = 0; i < 4; i++) begin
         beat(11, i, i + 1, 0, 0, i, 0); tick();
      end
      chk("full_ready4", 32'(rdy4), 32'd0);
      chk("full_err4", 32'(ef4), 32'd1);
      chk("full_wen4", 32'(wen4), 32'd0);
      chk("full_count4", 32'(count4), 32'd4);
      idle_inputs(); finish = 1; tick(); finish = 0;
      chk("full_flush_busy4", 32'(busy4), 32'd1);
      tick();
      chk("full_done_hold4", 32'(hold4), 32'd0);
      chk("full_done_busy4", 32'(busy4), 32'd0);

      // Reset the cycle after an accept drops the pending write
      start = 1; tick(); start = 0;
      beat(1, 3, 4, 5, 0, 0, 0); tick(); in_valid = 0;
      chk("pre_rst_wen", 32'(wen0), 32'd1);
      rst = 1; #1;
      chk("rst_drop_wen", 32'(wen0), 32'd0);
      tick();
      chk("post_rst_hold", 32'(hold0), 32'd1);
      chk("post_rst_busy", 32'(busy0), 32'd0);
      chk("post_rst_count", 32'(count0), 32'd0);
      chk("post_rst_addr", 32'(addr0), 32'd0);
      chk("post_rst_data", data0, 32'd0);
      rst = 0;

      // Randomized traffic against the reference model
      for (int n = 0; n < 2000; n++) begin
         start    = ($urandom_range(0, 19) == 0);
         finish   = ($urandom_range(0, 39) == 0);
         rst      = ($urandom_range(0, 299) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         in_kind  = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(16, 31))
                                                : 5'($urandom_range(0, 15));
         in_rs = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
         in_shamt = 5'($urandom); in_imm = 16'($urandom); in_target = 26'($urandom);
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
